serial_deserializer: RTL and testbench
======================================

Name: serial_deserializer

Overview:
- Serial-to-parallel receiver; the far end of the team's serial-load shift register link.
- Collects N qualified serial bits into a word and presents it on a valid/ready parallel interface.
- Supports frame resynchronisation and a sticky overflow flag.
- Sits between a serial bit stream (sender's serial_out) and a word-wide consumer.

Parameters:
- N, 4, word width in bits (N >= 2)
- MSB_FIRST, 1, 1 = first received bit lands in parallel_out[N-1]; 0 = first bit lands in parallel_out[0]

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- serial_in  input  1  serial data bit
- in_valid  input  1  serial_in qualifier; a bit is accepted when in_valid && in_ready
- frame_sync  input  1  with an accepted bit, marks it as bit 0 of a new word
- in_ready  output  1  receiver can accept a bit this cycle (combinational)
- parallel_out  output  N  assembled word (registered)
- out_valid  output  1  parallel_out holds an unconsumed word
- out_ready  input  1  consumer accepts word when out_valid && out_ready
- bit_count  output  $clog2(N+1)  bits accepted into the current partial word
- overflow  output  1  sticky: a bit was offered while in FULL and not accepted
- clear_ovf  input  1  clears overflow

Behaviour:
- Reset (rst=1 at rising edge) has priority over all inputs, including mid-word and in FULL.
- Reset values: parallel_out=0, out_valid=0, bit_count=0, overflow=0, state=IDLE.
- Shift register is internal. MSB_FIRST=1: sr <= {sr[N-2:0], serial_in}. MSB_FIRST=0: sr <= {serial_in, sr[N-1:1]}.
- State IDLE (bit_count=0, out_valid=0):
  - Accepted bit goes to SHIFT with bit_count=1.
- State SHIFT (1 <= bit_count <= N-1):
  - Accepted bit increments bit_count.
  - On the Nth bit: parallel_out <= completed word, out_valid <= 1, bit_count <= 0, go to FULL.
  - Latency: word visible on the same edge that accepts bit N.
- State FULL (out_valid=1):
  - in_ready = out_ready; everywhere else in_ready = 1.
  - out_ready=1 with no accepted bit: out_valid <= 0, go to IDLE.
  - out_ready=1 with in_valid=1 in the same cycle: word consumed and the bit accepted as bit 0 of the next word; go to SHIFT, bit_count=1. No bubble.
  - in_valid=1 with out_ready=0: bit dropped, overflow <= 1, state and parallel_out unchanged.
- frame_sync on an accepted bit in SHIFT discards the partial word; that bit becomes bit 0, bit_count=1.
  - In IDLE, frame_sync is redundant and harmless.
  - frame_sync on a dropped bit has no effect beyond the overflow rule.
- frame_sync with N=... any N: if the resync bit is also the Nth bit, it cannot complete a word. Resync always yields bit_count=1.
- in_valid=0: no state change. Bits with in_valid=0 are ignored regardless of serial_in and frame_sync.
- overflow: set takes priority over clear_ovf in the same cycle; otherwise clear_ovf clears it. Overflow never affects data flow.
- parallel_out holds its last value after consumption until the next word completes.
- bit_count wraps N-1 -> 0 on word completion; it never reaches N.
- FSM encoding is free; no latches; all outputs except in_ready are registered.

Test Plan (N=4, MSB_FIRST=1 unless stated):
- Reset then bits 1,0,1,0 with in_valid=1 and out_ready=0 -> after 4th edge parallel_out=4'b1010, out_valid=1, bit_count=0; before that edge bit_count steps 1,2,3.
- Repeat with MSB_FIRST=0 -> parallel_out=4'b0101.
- FULL with 1010; hold out_ready=0 and offer bit 1 -> in_ready=0, bit dropped, overflow=1, parallel_out stays 1010. Then clear_ovf=1 -> overflow=0.
- FULL with 1010; in the same cycle out_ready=1 and in_valid=1 with serial_in=1 -> out_valid=0, bit_count=1. Three more bits 1,0,0 -> parallel_out=4'b1100.
- Bits 1,1 then a frame_sync bit 0, then 1,1,0 -> bit_count goes 1,2,1,2,3; word completes as 4'b0110.
- Mid-word after 2 bits, and again in FULL, assert rst for one edge -> all outputs 0, state IDLE. The next 4 bits 0,0,1,1 give parallel_out=4'b0011.

Source files
------------

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: gathers N accepted serial bits into a word and
// hands it to a word-wide consumer over a valid/ready interface.
module serial_deserializer #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      serial_in,
  input  logic                      in_valid,
  input  logic                      frame_sync,
  output logic                      in_ready,
  output logic [N-1:0]              parallel_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(N+1)-1:0]    bit_count,
  output logic                      overflow,
  input  logic                      clear_ovf,
  output logic [1:0]                fsm_state
);

  localparam int CW = $clog2(N+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  // Handshakes: a serial bit transfers on a rising edge where in_valid && in_ready;
  // a word transfers on a rising edge where out_valid && out_ready. Neither
  // valid may depend on the matching ready; in_ready depends on out_ready only
  // while a word is waiting, which lets consume-and-accept happen in one cycle.

  logic [1:0]   state;
  logic [N-1:0] sr;
  logic [N-1:0] shifted;
  logic         accept;
  logic         last_bit;

  assign fsm_state = state;
  assign in_ready  = (state == FULL) ? out_ready : 1'b1;
  assign accept    = in_valid && in_ready;

  always_comb begin
    shifted = sr;
    if (MSB_FIRST) shifted = {sr[N-2:0], serial_in};
    else           shifted = {serial_in, sr[N-1:1]};
  end

  // A resync bit always restarts the word, so it can never be the completing bit.
  assign last_bit = (state == SHIFT) && !frame_sync && (bit_count == CW'(N-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sr           <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      bit_count    <= '0;
      overflow     <= 1'b0;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;
      else if (clear_ovf)        overflow <= 1'b0;

      // Stale bits from a discarded partial word are shifted out before completion.
      if (accept) sr <= shifted;

      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SHIFT;
            bit_count <= CW'(1);
          end
        end
        SHIFT: begin
          if (accept) begin
            if (last_bit) begin
              parallel_out <= shifted;
              out_valid    <= 1'b1;
              bit_count    <= '0;
              state        <= FULL;
            end else if (frame_sync) begin
              bit_count <= CW'(1);
            end else begin
              bit_count <= bit_count + CW'(1);
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              state     <= SHIFT;
              bit_count <= CW'(1);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: MSB-first and LSB-first instances share one
// stimulus stream and are checked every cycle against a bit-queue reference model.
module tb_serial_deserializer;

  localparam int N  = 4;
  localparam int CW = $clog2(N+1);

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic serial_in = 1'b0, in_valid = 1'b0, frame_sync = 1'b0;
  logic out_ready = 1'b0, clear_ovf = 1'b0;

  logic          in_ready_m, out_valid_m, overflow_m;
  logic [N-1:0]  parallel_out_m;
  logic [CW-1:0] bit_count_m;
  logic [1:0]    fsm_state_m;
  logic          in_ready_l, out_valid_l, overflow_l;
  logic [N-1:0]  parallel_out_l;
  logic [CW-1:0] bit_count_l;
  logic [1:0]    fsm_state_l;

  serial_deserializer #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
    .frame_sync(frame_sync), .in_ready(in_ready_m), .parallel_out(parallel_out_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .bit_count(bit_count_m),
    .overflow(overflow_m), .clear_ovf(clear_ovf), .fsm_state(fsm_state_m)
  );

  serial_deserializer #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
    .frame_sync(frame_sync), .in_ready(in_ready_l), .parallel_out(parallel_out_l),
    .out_valid(out_valid_l), .out_ready(out_ready), .bit_count(bit_count_l),
    .overflow(overflow_l), .clear_ovf(clear_ovf), .fsm_state(fsm_state_l)
  );

  // reference model: bits of the partial word in arrival order
  logic         bits_q[$];
  logic         m_full = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [N-1:0] m_word_msb = '0;
  logic [N-1:0] m_word_lsb = '0;
  logic [N-1:0] exp_q[$];  // completed MSB-first words awaiting consumption

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs for one cycle, check ready before the edge and all
  // registered outputs just after it
  task automatic step(input logic r, input logic sv, input logic iv,
                      input logic fs, input logic ordy, input logic clr);
    logic exp_ready, acc;
    rst = r; serial_in = sv; in_valid = iv; frame_sync = fs;
    out_ready = ordy; clear_ovf = clr;
    #1;
    exp_ready = m_full ? ordy : 1'b1;
    check("in_ready_msb", 32'(in_ready_m), 32'(exp_ready));
    check("in_ready_lsb", 32'(in_ready_l), 32'(exp_ready));
    @(posedge clk);
    acc = iv && exp_ready;
    if (r) begin
      bits_q.delete();
      exp_q.delete();
      m_full = 1'b0; m_ovf = 1'b0; m_word_msb = '0; m_word_lsb = '0;
    end else begin
      if (iv && !exp_ready) m_ovf = 1'b1;
      else if (clr)         m_ovf = 1'b0;
      if (m_full && ordy) begin
        m_full = 1'b0;
        void'(exp_q.pop_front());
      end
      if (acc) begin
        if (fs) bits_q.delete();
        bits_q.push_back(sv);
        if (bits_q.size() == N) begin
          for (int i = 0; i < N; i++) begin
            m_word_msb[N-1-i] = bits_q[i];
            m_word_lsb[i]     = bits_q[i];
          end
          exp_q.push_back(m_word_msb);
          bits_q.delete();
          m_full = 1'b1;
        end
      end
    end
    #1;
    check("out_valid_msb", 32'(out_valid_m), 32'(m_full));
    check("out_valid_lsb", 32'(out_valid_l), 32'(m_full));
    check("bit_count_msb", 32'(bit_count_m), 32'(bits_q.size()));
    check("bit_count_lsb", 32'(bit_count_l), 32'(bits_q.size()));
    check("word_msb", 32'(parallel_out_m), 32'(m_word_msb));
    check("word_lsb", 32'(parallel_out_l), 32'(m_word_lsb));
    check("overflow_msb", 32'(overflow_m), 32'(m_ovf));
    check("overflow_lsb", 32'(overflow_l), 32'(m_ovf));
  endtask

  task automatic send4(input logic [3:0] b);  // b[3] is sent first
    for (int i = 3; i >= 0; i--) step(1'b0, b[i], 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_word_const", 32'(parallel_out_m), 32'h0);

    send4(4'b1010);
    check("tp_word_1010", 32'(parallel_out_m), 32'ha);
    check("tp_word_0101", 32'(parallel_out_l), 32'h5);

    // dropped bit while full, then clear
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("tp_ovf_set", 32'(overflow_m), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("tp_ovf_clear", 32'(overflow_m), 32'h0);

    // consume and accept in the same cycle
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("tp_word_1100", 32'(parallel_out_m), 32'hc);

    // set beats clear in the same cycle
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // frame resync mid-word
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("tp_word_0110", 32'(parallel_out_m), 32'h6);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // resync arriving where the last bit would be
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("tp_resync_last", 32'(bit_count_m), 32'h1);

    // reset mid-word and while full
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send4(4'b1111);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("tp_reset_full", 32'(out_valid_m), 32'h0);
    send4(4'b0011);
    check("tp_word_0011", 32'(parallel_out_m), 32'h3);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 59) == 0),
           1'($urandom),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
